// File: rtl/detector_jogada_pkg.sv
// Shared game definitions for detector_jogada: FSM state codes, default timing
// constants and the one-hot test used by the button detector.
package detector_jogada_pkg;

  localparam int N_BOTOES               = 4;
  localparam int DEBOUNCE_CICLOS_PADRAO = 1000;
  localparam int TIMEOUT_CICLOS_PADRAO  = 5000;

  typedef enum logic [2:0] {
    ESPERA     = 3'd0,
    ESTABILIZA = 3'd1,
    PULSO      = 3'd2,
    SOLTURA    = 3'd3,
    TIMEOUT    = 3'd4
  } estado_t;

  // True when exactly one button is down; clearing the lowest set bit must leave zero.
  function automatic logic um_bit(input logic [N_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - N_BOTOES'(1))) == '0);
  endfunction

endpackage

// File: rtl/detector_jogada_sincronizador_2ff.sv
// Two-flop synchronizer bringing asynchronous levels into the clock domain.
module sincronizador_2ff #(
  parameter int LARGURA = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  logic [LARGURA-1:0] meta;
  logic [LARGURA-1:0] sinc;

  // NOTE: non-blocking assignments make both stages sample the old values,
  // so the chain really is two flops deep instead of collapsing into one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      sinc <= '0;
    end else begin
      meta <= d;
      sinc <= meta;
    end
  end

  assign q = sinc;

endmodule

// File: rtl/detector_jogada.sv
// Debounced push-button press detector emitting one jogada pulse per accepted press.
// Optional idle timeout is compiled in with `define DETECTOR_TIMEOUT_EN.
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
  parameter int TIMEOUT_CICLOS  = TIMEOUT_CICLOS_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                habilita,
  input  logic [N_BOTOES-1:0] botoes,
  output logic                jogada,
  output logic [N_BOTOES-1:0] codigo,
  output logic                timeout,
  output logic [2:0]          db_estado
);

  localparam int MAX_CICLOS = (DEBOUNCE_CICLOS > TIMEOUT_CICLOS) ? DEBOUNCE_CICLOS
                                                                   : TIMEOUT_CICLOS;
  localparam int CNT_W      = (MAX_CICLOS > 1) ? $clog2(MAX_CICLOS) : 1;

  localparam logic [CNT_W-1:0] UM      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);

  logic [N_BOTOES-1:0] sinc;
  logic [N_BOTOES-1:0] candidato;
  logic [N_BOTOES-1:0] codigo_q;
  logic [CNT_W-1:0]    contador;
  logic                jogada_q;
  estado_t             estado;

  sincronizador_2ff #(
    .LARGURA(N_BOTOES)
  ) u_sinc (
    .clock(clock),
    .reset(reset),
    .d    (botoes),
    .q    (sinc)
  );

`ifdef DETECTOR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_FIM = CNT_W'(TIMEOUT_CICLOS - 1);
  logic timeout_q;
`endif

  // One counter serves debounce, release debounce and idle timeout; every state
  // change clears it and each state stops it at its own terminal value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= ESPERA;
      contador  <= '0;
      candidato <= '0;
      codigo_q  <= '0;
      jogada_q  <= 1'b0;
`ifdef DETECTOR_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      jogada_q <= 1'b0;
      case (estado)
        ESPERA: begin
          if (habilita && um_bit(sinc)) begin
            candidato <= sinc;
            contador  <= '0;
            estado    <= ESTABILIZA;
          end
`ifdef DETECTOR_TIMEOUT_EN
          else if (habilita) begin
            if (contador == TMO_FIM) begin
              contador  <= '0;
              timeout_q <= 1'b1;
              estado    <= TIMEOUT;
            end else begin
              contador <= contador + UM;
            end
          end
`endif
          else begin
            contador <= '0;
          end
        end

        ESTABILIZA: begin
          if (!habilita || (sinc != candidato)) begin
            contador <= '0;
            estado   <= ESPERA;
          end else if (contador == DEB_FIM) begin
            codigo_q <= candidato;
            jogada_q <= 1'b1;
            contador <= '0;
            estado   <= PULSO;
          end else begin
            contador <= contador + UM;
          end
        end

        PULSO: begin
          contador <= '0;
          estado   <= SOLTURA;
        end

        // Any button seen down, including a newly pressed one, restarts the release count.
        SOLTURA: begin
          if (sinc != '0) begin
            contador <= '0;
          end else if (contador == DEB_FIM) begin
            contador <= '0;
            estado   <= ESPERA;
          end else begin
            contador <= contador + UM;
          end
        end

        TIMEOUT: begin
`ifdef DETECTOR_TIMEOUT_EN
          if (!habilita) begin
            timeout_q <= 1'b0;
            contador  <= '0;
            estado    <= ESPERA;
          end
`else
          contador <= '0;
          estado   <= ESPERA;
`endif
        end

        default: begin
          contador <= '0;
          estado   <= ESPERA;
        end
      endcase
    end
  end

  assign jogada    = jogada_q;
  assign codigo    = codigo_q;
  assign db_estado = estado;
`ifdef DETECTOR_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Directed self-checking bench for detector_jogada with DEBOUNCE_CICLOS=4, TIMEOUT_CICLOS=20.
module tb_detector_jogada;
  import detector_jogada_pkg::*;

  localparam int D = 4;
  localparam int T = 20;

  logic       clock    = 1'b0;
  logic       reset    = 1'b0;
  logic       habilita = 1'b0;
  logic [3:0] botoes   = 4'b0000;
  logic       jogada;
  logic [3:0] codigo;
  logic       timeout;
  logic [2:0] db_estado;

  int checks = 0;
  int errors = 0;
  int pulsos = 0;
  int p0     = 0;

  detector_jogada #(
    .DEBOUNCE_CICLOS(D),
    .TIMEOUT_CICLOS (T)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .habilita (habilita),
    .botoes   (botoes),
    .jogada   (jogada),
    .codigo   (codigo),
    .timeout  (timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Pulse counter sampled mid-cycle, away from the active edge.
  always @(negedge clock) if (jogada) pulsos++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_jogada", 32'(jogada), 32'd0);
    check("rst_codigo", 32'(codigo), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_estado", 32'(db_estado), 32'd0);
    reset = 1'b1;
    tick(1);

    // Stable press of 0100: pulse after edge 6, states 0,1,2,3
    p0 = pulsos;
    habilita = 1'b1;
    botoes = 4'b0100;
    tick(2);
    check("t1_espera", 32'(db_estado), 32'd0);
    tick(1);
    check("t1_estabiliza", 32'(db_estado), 32'd1);
    tick(3);
    check("t1_estab_fim", 32'(db_estado), 32'd1);
    check("t1_sem_pulso", 32'(jogada), 32'd0);
    check("t1_codigo_antes", 32'(codigo), 32'd0);
    tick(1);
    check("t1_pulso", 32'(jogada), 32'd1);
    check("t1_estado_pulso", 32'(db_estado), 32'd2);
    check("t1_codigo", 32'(codigo), 32'h4);
    tick(1);
    check("t1_pulso_fim", 32'(jogada), 32'd0);
    check("t1_soltura", 32'(db_estado), 32'd3);
    botoes = 4'b0000;
    tick(5);
    check("t1_soltura_espera", 32'(db_estado), 32'd3);
    tick(1);
    check("t1_volta_espera", 32'(db_estado), 32'd0);
    check("t1_n_pulsos", 32'(pulsos - p0), 32'd1);

    // Bouncing 0001/0000 every two cycles, then stable 0001
    p0 = pulsos;
    repeat (3) begin
      botoes = 4'b0001;
      tick(2);
      botoes = 4'b0000;
      tick(2);
    end
    check("t2_bounce_sem_pulso", 32'(pulsos - p0), 32'd0);
    check("t2_bounce_codigo", 32'(codigo), 32'h4);
    botoes = 4'b0001;
    tick(6);
    check("t2_antes_pulso", 32'(jogada), 32'd0);
    tick(1);
    check("t2_pulso", 32'(jogada), 32'd1);
    check("t2_codigo", 32'(codigo), 32'h1);
    tick(1);
    check("t2_n_pulsos", 32'(pulsos - p0), 32'd1);
    botoes = 4'b0000;
    tick(6);
    check("t2_volta_espera", 32'(db_estado), 32'd0);

    // Two buttons at once are never accepted
    p0 = pulsos;
    botoes = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t3_estado_espera", 32'(db_estado), 32'd0);
    end
    check("t3_codigo", 32'(codigo), 32'h1);
    check("t3_n_pulsos", 32'(pulsos - p0), 32'd0);
    botoes = 4'b0000;
    habilita = 1'b0;
    tick(1);
    habilita = 1'b1;
    tick(2);

    // Second button during SOLTURA is ignored until the release debounce completes
    p0 = pulsos;
    botoes = 4'b1000;
    tick(7);
    check("t4_pulso", 32'(jogada), 32'd1);
    check("t4_codigo", 32'(codigo), 32'h8);
    tick(1);
    check("t4_soltura", 32'(db_estado), 32'd3);
    botoes = 4'b1010;
    tick(4);
    check("t4_dois_botoes", 32'(db_estado), 32'd3);
    botoes = 4'b0010;
    tick(4);
    check("t4_segundo_botao", 32'(db_estado), 32'd3);
    botoes = 4'b0000;
    tick(3);
    check("t4_soltura_curta", 32'(db_estado), 32'd3);
    botoes = 4'b0010;
    tick(4);
    check("t4_repress", 32'(db_estado), 32'd3);
    check("t4_n_pulsos_1", 32'(pulsos - p0), 32'd1);
    check("t4_codigo_mantido", 32'(codigo), 32'h8);
    botoes = 4'b0000;
    tick(5);
    check("t4_soltura_quase", 32'(db_estado), 32'd3);
    tick(1);
    check("t4_espera", 32'(db_estado), 32'd0);
    botoes = 4'b0010;
    tick(6);
    check("t4_antes_pulso2", 32'(jogada), 32'd0);
    tick(1);
    check("t4_pulso2", 32'(jogada), 32'd1);
    check("t4_codigo2", 32'(codigo), 32'h2);
    tick(1);
    check("t4_n_pulsos_2", 32'(pulsos - p0), 32'd2);
    botoes = 4'b0000;
    tick(6);
    check("t4_fim_espera", 32'(db_estado), 32'd0);

    // Reset two cycles into ESTABILIZA aborts the press
    botoes = 4'b0100;
    tick(4);
    check("t5_estabiliza", 32'(db_estado), 32'd1);
    reset = 1'b0;
    #1;
    check("t5_rst_jogada", 32'(jogada), 32'd0);
    check("t5_rst_codigo", 32'(codigo), 32'd0);
    check("t5_rst_estado", 32'(db_estado), 32'd0);
    check("t5_rst_timeout", 32'(timeout), 32'd0);
    tick(2);
    reset = 1'b1;
    p0 = pulsos;
    tick(6);
    check("t5_sem_pulso", 32'(pulsos - p0), 32'd0);
    check("t5_novo_debounce", 32'(db_estado), 32'd1);
    tick(1);
    check("t5_pulso_novo", 32'(jogada), 32'd1);
    check("t5_codigo_novo", 32'(codigo), 32'h4);
    tick(1);
    botoes = 4'b0000;
    tick(6);
    check("t5_espera", 32'(db_estado), 32'd0);

    // Idle with habilita=1: timeout only when the feature is compiled in
    habilita = 1'b0;
    tick(1);
    check("t6_timeout_off", 32'(timeout), 32'd0);
    habilita = 1'b1;
    tick(T - 1);
    check("t6_antes_timeout", 32'(timeout), 32'd0);
    tick(1);
`ifdef DETECTOR_TIMEOUT_EN
    check("t6_timeout", 32'(timeout), 32'd1);
    check("t6_estado_timeout", 32'(db_estado), 32'd4);
    tick(3);
    check("t6_timeout_mantido", 32'(timeout), 32'd1);
    habilita = 1'b0;
    tick(1);
    check("t6_timeout_limpo", 32'(timeout), 32'd0);
    check("t6_volta_espera", 32'(db_estado), 32'd0);
`else
    check("t6_timeout_fixo", 32'(timeout), 32'd0);
    check("t6_estado_espera", 32'(db_estado), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/detector_jogada.md
DETECTOR_JOGADA -- requirements
Module: detector_jogada

Interface
REQ-001 Parameter: DEBOUNCE_CICLOS, 1000, cycles a level must stay stable to count as a press or a release.
REQ-002 Parameter: TIMEOUT_CICLOS, 5000, idle cycles before timeout; used only when the timeout feature is compiled in.
REQ-003 Port: clock  input  1  single clock; all flops on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: habilita  input  1  enables detection of new presses.
REQ-006 Port: botoes  input  4  raw, asynchronous push-button levels; 1 = pressed.
REQ-007 Port: jogada  output  1  single-cycle pulse per accepted press; feeds the control unit's jogada input.
REQ-008 Port: codigo  output  4  one-hot code of the last accepted button, registered.
REQ-009 Port: timeout  output  1  no press within TIMEOUT_CICLOS while enabled.
REQ-010 Port: db_estado  output  3  current FSM state code, for debug.

Function
REQ-011 botoes SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value (sinc).
REQ-012 FSM SHALL use these states and codes: ESPERA=0, ESTABILIZA=1, PULSO=2, SOLTURA=3, TIMEOUT=4.
REQ-013 ESPERA: on habilita=1 and sinc with exactly one bit set, SHALL capture sinc into the candidate register, clear the debounce counter and go to ESTABILIZA; zero bits or more than one bit set means stay.
REQ-014 ESTABILIZA: sinc differs from the candidate, or habilita=0 -> go to ESPERA; otherwise increment the counter; at counter==DEBOUNCE_CICLOS-1, load codigo with the candidate and go to PULSO.
REQ-015 PULSO: jogada=1 for exactly this one cycle, then go to SOLTURA unconditionally; habilita is ignored.
REQ-016 SOLTURA: wait for sinc==0 for DEBOUNCE_CICLOS consecutive cycles (any nonzero sample restarts the count), then go to ESPERA; no new jogada is possible until then.
REQ-017 Latency: with the raw press stable and edge 0 being the first edge that samples it, jogada SHALL be high in the cycle after edge DEBOUNCE_CICLOS+2.
REQ-018 codigo SHALL hold its value until the next accepted press; codigo SHALL never change on a rejected or bouncing press.
REQ-019 A second button pressed during SOLTURA SHALL be ignored until all buttons have been released and the release debounce has completed.
REQ-020 Counter width SHALL be $clog2 of max(DEBOUNCE_CICLOS, TIMEOUT_CICLOS) bits; the counter SHALL never wrap.

Reset
REQ-021 reset=0 SHALL asynchronously force: state ESPERA, sync flops 0, counters 0, candidate 0, codigo=0, jogada=0, timeout=0, db_estado=0.
REQ-022 Reset asserted mid-debounce or during PULSO SHALL abort the operation with no jogada emitted afterwards; after release, a press still held requires a full new debounce.

Configuration
REQ-023 Macro DETECTOR_TIMEOUT_EN, when defined, SHALL enable the following: a timeout counter runs in ESPERA while habilita=1 and clears otherwise; at TIMEOUT_CICLOS-1 the FSM goes to TIMEOUT, where timeout=1 holds until habilita=0, which returns the FSM to ESPERA.
REQ-024 When DETECTOR_TIMEOUT_EN is undefined, the timeout port SHALL remain present and be tied to 0, and state TIMEOUT SHALL be unreachable.

Structure
REQ-025 The state encodings and the default DEBOUNCE_CICLOS and TIMEOUT_CICLOS values SHALL live in the shared game package/header.
REQ-026 The 2-flop synchronizer SHALL be a separate sub-module, sincronizador_2ff, parameterized by width.

Verification (DEBOUNCE_CICLOS=4, TIMEOUT_CICLOS=20)
REQ-027 Hold botoes=0100 with habilita=1 -> jogada pulses exactly one cycle at edge 6; codigo=0100; db_estado goes 0,1,2,3.
REQ-028 Bounce botoes 0001/0000 every 2 cycles, then hold 0001 -> no pulse during the bounce, exactly one pulse after stable; codigo=0001.
REQ-029 Hold botoes=0011 -> no jogada, codigo unchanged, state stays 0.
REQ-030 Hold 1000, then press 0010 during SOLTURA, then release all -> exactly one jogada, codigo=1000; the next 0010 press is accepted only after 4 cycles at 0000.
REQ-031 Drive reset=0 two cycles into ESTABILIZA -> all outputs 0 immediately, no jogada afterwards; with DETECTOR_TIMEOUT_EN, 20 idle cycles with habilita=1 -> timeout=1, cleared by habilita=0.
